// File: rtl/lzma_stream_arbiter_if.sv
// lzma_stream_arbiter_if: requester, compressor and framed-output signals of the stream arbiter.
// The master modport is the arbiter's view; slave is the surrounding requesters/compressor/sink.
interface lzma_stream_arbiter_if #(parameter int NCH = 2);
    localparam int CHW = ($clog2(NCH) > 1) ? $clog2(NCH) : 1;
    logic [NCH-1:0]   s_ready;
    logic [NCH-1:0]   s_valid;
    logic [NCH-1:0]   s_last;
    logic [NCH*8-1:0] s_data;
    logic             c_ready;
    logic             c_valid;
    logic             c_last;
    logic [7:0]       c_data;
    logic             c_ovalid;
    logic [7:0]       c_odata;
    logic             c_oend;
    logic             o_valid;
    logic [7:0]       o_data;
    logic             o_end;
    logic [CHW-1:0]   o_chan;
    logic             err;
    modport master (
        output s_ready, c_valid, c_last, c_data, o_valid, o_data, o_end, o_chan, err,
        input  s_valid, s_last, s_data, c_ready, c_ovalid, c_odata, c_oend
    );
    modport slave (
        input  s_ready, c_valid, c_last, c_data, o_valid, o_data, o_end, o_chan, err,
        output s_valid, s_last, s_data, c_ready, c_ovalid, c_odata, c_oend
    );
endinterface

// File: rtl/lzma_stream_arbiter.sv
// lzma_stream_arbiter: round-robin whole-stream sharing of one LZMA compressor among NCH requesters.
// Define LZMA_HDR_EN to prepend the 13-byte LZMA file header to every granted stream.
module lzma_stream_arbiter #(parameter int NCH = 2) (
    input  logic                 clk,
    input  logic                 rst,
    lzma_stream_arbiter_if.master bus
);
    localparam int CHW = ($clog2(NCH) > 1) ? $clog2(NCH) : 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;
`ifdef LZMA_HDR_EN
    localparam logic [1:0] HDR   = 2'd1;
    localparam logic [7:0] HDR_BYTES [13] = '{8'h5E, 8'h00, 8'h00, 8'h02, 8'h00, 8'hFF, 8'hFF,
                                              8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [3:0]     hcnt_q, hcnt_d;
`endif
    logic [1:0]     state_q, state_d;
    logic [CHW-1:0] rr_q, rr_d, gnt_q, gnt_d, pick, cand;
    logic [CHW-1:0] o_chan_q, o_chan_d;
    logic [7:0]     o_data_q, o_data_d, sel_data;
    logic           o_valid_q, o_valid_d, o_end_q, o_end_d, err_q, err_d;
    logic           hs_last;
    // First requesting channel at or after rr_q, wrapping; lowest offset wins.
    always_comb begin
        pick = rr_q;
        cand = rr_q;
        for (int i = NCH - 1; i >= 0; i--) begin
            cand = CHW'((int'(rr_q) + i) % NCH);
            pick = bus.s_valid[cand] ? cand : pick;
        end
    end
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NCH; k++)
            sel_data = (CHW'(k) == gnt_q) ? bus.s_data[k*8 +: 8] : sel_data;
    end
    assign bus.c_valid = (state_q == RUN) & bus.s_valid[gnt_q];
    assign bus.c_last  = bus.s_last[gnt_q];
    assign bus.c_data  = sel_data;
    assign bus.s_ready = (state_q == RUN) ? (NCH'(bus.c_ready) << gnt_q) : '0;
    assign hs_last     = bus.c_valid & bus.c_ready & bus.c_last;
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gnt_d     = gnt_q;
        o_valid_d = 1'b0;
        o_end_d   = 1'b0;
        o_data_d  = o_data_q;
        o_chan_d  = o_chan_q;
        err_d     = err_q;
`ifdef LZMA_HDR_EN
        hcnt_d    = hcnt_q;
`endif
        case (state_q)
            IDLE: begin
                err_d   = err_q | bus.c_ovalid | bus.c_oend;
                gnt_d   = (|bus.s_valid) ? pick : gnt_q;
`ifdef LZMA_HDR_EN
                state_d = (|bus.s_valid) ? HDR : IDLE;
`else
                state_d = (|bus.s_valid) ? RUN : IDLE;
`endif
            end
`ifdef LZMA_HDR_EN
            HDR: begin
                err_d     = err_q | bus.c_ovalid | bus.c_oend;
                o_valid_d = 1'b1;
                o_data_d  = HDR_BYTES[hcnt_q];
                o_chan_d  = gnt_q;
                hcnt_d    = (hcnt_q == 4'd12) ? 4'd0 : hcnt_q + 4'd1;
                state_d   = (hcnt_q == 4'd12) ? RUN : HDR;
            end
`endif
            default: begin
                o_valid_d = bus.c_ovalid;
                o_data_d  = bus.c_odata;
                o_end_d   = bus.c_oend;
                o_chan_d  = gnt_q;
                if (state_q == RUN) begin
                    err_d   = err_q | bus.c_oend;
                    state_d = hs_last ? DRAIN : RUN;
                end else if (bus.c_oend) begin
                    rr_d    = (gnt_q == CHW'(NCH - 1)) ? '0 : gnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            gnt_q     <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_end_q   <= 1'b0;
            o_chan_q  <= '0;
            err_q     <= 1'b0;
`ifdef LZMA_HDR_EN
            hcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_end_q   <= o_end_d;
            o_chan_q  <= o_chan_d;
            err_q     <= err_d;
`ifdef LZMA_HDR_EN
            hcnt_q    <= hcnt_d;
`endif
        end
    end
    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = o_data_q;
    assign bus.o_end   = o_end_q;
    assign bus.o_chan  = o_chan_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_lzma_stream_arbiter.sv
// tb_lzma_stream_arbiter: randomized streams through the arbiter with a toy echo compressor,
// checked against a stream-level round-robin model and an expected o_* event queue.
module tb_lzma_stream_arbiter;
    localparam int NCH = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    lzma_stream_arbiter_if #(.NCH(NCH)) bus ();
    lzma_stream_arbiter #(.NCH(NCH)) dut (.clk(clk), .rst(rst), .bus(bus.master));
    int vectors = 0;
    int errors  = 0;
    byte unsigned src_d [NCH][$];
    bit           src_l [NCH][$];
    bit           begun [NCH];
    logic [31:0]  exp_q [$];
    int           gseq  [$];
    int           cur = -1, ptr = 0, oend_cnt = 0;
    bit           pend_v = 0, err_exp = 0, bp = 0, inject = 0;
    byte unsigned pend_d = 0;
`ifdef LZMA_HDR_EN
    logic [7:0] hdr [13] = '{8'h5E, 8'h00, 8'h00, 8'h02, 8'h00, 8'hFF, 8'hFF,
                             8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`endif
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask
    task automatic add_stream(input int ch, input int len, input bit seq);
        for (int i = 0; i < len; i++) begin
            src_d[ch].push_back(seq ? 8'(i) : 8'($urandom));
            src_l[ch].push_back(i == len - 1);
        end
    endtask
    function automatic bit busy();
        bit b = (cur >= 0) || (oend_cnt > 0) || pend_v || (exp_q.size() > 0);
        for (int k = 0; k < NCH; k++) b = b || (src_d[k].size() > 0);
        return b;
    endfunction
    task automatic step();
        logic [31:0]    got;
        logic [NCH-1:0] own;
        bit             hs;
        @(negedge clk);
        if (bus.o_valid || bus.o_end) begin
            got = {14'd0, bus.o_end, bus.o_valid, bus.o_valid ? bus.o_data : 8'h00, 8'(bus.o_chan)};
            if (exp_q.size() == 0) check("o_unexpected", got, 32'h0);
            else check("o_event", got, exp_q.pop_front());
        end
        check("err", 32'(bus.err), 32'(err_exp));
        bus.c_ovalid = pend_v | inject;
        bus.c_odata  = pend_v ? pend_d : 8'hC3;
        bus.c_oend   = (oend_cnt == 1);
        if (inject) err_exp = 1'b1;
        inject = 1'b0;
        pend_v = 1'b0;
        if (oend_cnt > 0) oend_cnt--;
        if (bus.c_oend) begin
            exp_q.push_back({14'd0, 2'b10, 8'h00, 8'(cur)});
            ptr = (cur + 1) % NCH;
            cur = -1;
        end
        if (cur < 0) begin
            for (int i = 0; i < NCH; i++)
                if (cur < 0 && src_d[(ptr + i) % NCH].size() > 0) cur = (ptr + i) % NCH;
`ifdef LZMA_HDR_EN
            if (cur >= 0)
                for (int i = 0; i < 13; i++) exp_q.push_back({14'd0, 2'b01, hdr[i], 8'(cur)});
`endif
        end
        for (int k = 0; k < NCH; k++) begin
            bus.s_valid[k]       = src_d[k].size() > 0 && (!begun[k] || $urandom_range(3) != 0);
            bus.s_data[k*8 +: 8] = src_d[k].size() > 0 ? src_d[k][0] : 8'h00;
            bus.s_last[k]        = src_l[k].size() > 0 ? src_l[k][0] : 1'b0;
        end
        bus.c_ready = bp ? 1'($urandom_range(1)) : 1'b1;
        #1;
        own = (cur >= 0) ? (NCH'(1) << cur) : '0;
        check("s_ready_other", 32'(bus.s_ready & ~own), 32'h0);
        hs = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (bus.s_valid[k] && bus.s_ready[k]) begin
                hs = 1'b1;
                check("hs_chan", 32'(k), 32'(cur));
                check("c_byte", 32'({bus.c_last, bus.c_data}), 32'({src_l[k][0], src_d[k][0]}));
                if (!begun[k]) gseq.push_back(k);
                begun[k] = 1'b1;
                pend_v   = 1'b1;
                pend_d   = src_d[k][0] ^ 8'h5A;
                exp_q.push_back({14'd0, 2'b01, pend_d, 8'(cur)});
                if (src_l[k][0]) begin
                    begun[k] = 1'b0;
                    oend_cnt = 2;
                end
                void'(src_d[k].pop_front());
                void'(src_l[k].pop_front());
            end
        end
        check("c_handshake", 32'(bus.c_valid & bus.c_ready), 32'(hs));
    endtask
    task automatic run(input int budget);
        int n = 0;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        check("timeout", 32'(n < budget), 32'h1);
        repeat (3) step();
    endtask
    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, 32'(bus.s_ready), 32'h0);
        check({tag, "_c_valid"}, 32'(bus.c_valid), 32'h0);
        check({tag, "_o"}, 32'({bus.o_valid, bus.o_data, bus.o_end, bus.o_chan}), 32'h0);
        check({tag, "_err"}, 32'(bus.err), 32'h0);
    endtask
    task automatic mid_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.s_valid = '0;
        bus.c_ovalid = 1'b0;
        bus.c_oend = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            src_d[k].delete();
            src_l[k].delete();
            begun[k] = 1'b0;
        end
        exp_q.delete();
        cur = -1; ptr = 0; oend_cnt = 0; pend_v = 0; err_exp = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
    endtask
    initial begin
        bus.s_valid = '1; bus.s_last = '0; bus.s_data = '0; bus.c_ready = 1'b1;
        bus.c_ovalid = 1'b0; bus.c_odata = '0; bus.c_oend = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        bus.s_valid = '0;
        // Contention from reset: both channels always have work queued.
        for (int s = 0; s < 3; s++) begin
            add_stream(0, $urandom_range(1, 20), 1'b0);
            add_stream(1, $urandom_range(1, 20), 1'b0);
        end
        run(2000);
        check("grant_count", 32'(gseq.size()), 32'd6);
        for (int i = 0; i < gseq.size(); i++) check("grant_order", 32'(gseq[i]), 32'(i % 2));
        add_stream(0, 16, 1'b1);
        run(500);
        bp = 1'b1;
        add_stream(1, 1000, 1'b0);
        run(20000);
        bp = 1'b0;
        add_stream(1, 1, 1'b0);
        run(100);
        inject = 1'b1;
        repeat (5) step();
        add_stream(0, 5, 1'b0);
        run(200);
        add_stream(1, 200, 1'b0);
        repeat (40) step();
        mid_reset();
        gseq.delete();
        add_stream(0, 4, 1'b0);
        add_stream(1, 4, 1'b0);
        run(500);
        check("post_reset_first_grant", 32'(gseq.size() > 0 ? gseq[0] : -1), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
